// File: rtl/y_zigzag_serializer_pkg.sv
// y_zigzag_serializer_pkg: shared JPEG constants, zigzag tables and serializer state type
package y_zigzag_serializer_pkg;
    localparam int COEFF_W_DEF = 11;
    localparam int ZZ_N = 64;
    typedef enum logic {IDLE, STREAM} state_t;
    // Row/column of each zigzag position, DC first
    localparam logic [2:0] ZZ_ROW [0:63] = '{
        3'd0, 3'd0, 3'd1, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0,
        3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3,
        3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6,
        3'd7, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd5, 3'd6, 3'd7, 3'd7
    };
    localparam logic [2:0] ZZ_COL [0:63] = '{
        3'd0, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5,
        3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6, 3'd5, 3'd4,
        3'd3, 3'd2, 3'd1, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3,
        3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd5, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd7
    };
endpackage

// File: rtl/zigzag_index_rom.sv
// zigzag_index_rom: combinational map from zigzag position to block row/column
module zigzag_index_rom
    import y_zigzag_serializer_pkg::*;
(
    input  logic [5:0] i_k,
    output logic [2:0] o_row,
    output logic [2:0] o_col
);
    assign o_row = ZZ_ROW[i_k];
    assign o_col = ZZ_COL[i_k];
endmodule

// File: rtl/y_zigzag_serializer.sv
// y_zigzag_serializer: buffers an 8x8 quantized Y block and streams it in zigzag order
// with ready/valid handshaking and gapless back-to-back blocks.
module y_zigzag_serializer
    import y_zigzag_serializer_pkg::*;
#(
    parameter int COEFF_W = COEFF_W_DEF,
    parameter int BLK_N   = ZZ_N
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                enable,
    input  logic signed [0:7][0:7][COEFF_W-1:0] Q,
    output logic                                in_ready,
    output logic signed [COEFF_W-1:0]           zz_data,
    output logic [5:0]                          zz_index,
    output logic                                zz_valid,
    output logic                                zz_last,
    input  logic                                zz_ready
);
    state_t r_state, w_state_nxt;
    logic [5:0] r_k, w_k_nxt;
    logic [0:7][0:7][COEFF_W-1:0] r_buf;
    logic [2:0] w_row, w_col;
    logic w_beat, w_last_acc, w_cap;

    zigzag_index_rom u_rom (.i_k(r_k), .o_row(w_row), .o_col(w_col));

    assign zz_valid   = r_state == STREAM;
    assign zz_index   = r_k;
    assign zz_last    = zz_valid && r_k == 6'(BLK_N - 1);
    assign zz_data    = zz_valid ? $signed(r_buf[w_row][w_col]) : '0;
    assign w_beat     = zz_valid && zz_ready;
    assign w_last_acc = w_beat && zz_last;
    // Accepting a new block on the final beat keeps the stream gapless
    assign in_ready   = r_state == IDLE || w_last_acc;
    assign w_cap      = enable && in_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_state_nxt = w_cap ? STREAM : w_last_acc ? IDLE : r_state;
        w_k_nxt     = (w_cap || w_last_acc) ? '0 : w_beat ? r_k + 6'd1 : r_k;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_k     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
        end
    end

    // Block storage is never cleared; it is only visible after a capture
    always_ff @(posedge clk) begin
        if (w_cap) r_buf <= Q;
    end
endmodule

// File: tb/tb_y_zigzag_serializer.sv
// tb_y_zigzag_serializer: directed tables, corner sequences and random blocks against a
// diagonal-walk zigzag reference model.
module tb_y_zigzag_serializer;
    localparam int W = 11;
    typedef logic signed [0:7][0:7][W-1:0] blk_t;
    typedef struct {
        int idx;
        int data;
        bit last;
    } vec_t;

    logic clk = 1'b0, rst = 1'b1, enable = 1'b0, zz_ready = 1'b1;
    blk_t q_in = '0;
    logic in_ready, zz_valid, zz_last;
    logic signed [W-1:0] zz_data;
    logic [5:0] zz_index;

    int n_chk = 0, n_err = 0;
    logic signed [W-1:0] got_data[$], exp_data[$];
    int got_idx[$], exp_idx[$];
    bit got_last[$], exp_last[$];
    vec_t ramp_tab[11];

    always #5 clk = ~clk;

    y_zigzag_serializer dut (
        .clk(clk), .rst(rst), .enable(enable), .Q(q_in), .in_ready(in_ready),
        .zz_data(zz_data), .zz_index(zz_index), .zz_valid(zz_valid), .zz_last(zz_last),
        .zz_ready(zz_ready)
    );

    always @(negedge clk) begin
        if (!rst && zz_valid && zz_ready) begin
            got_data.push_back(zz_data);
            got_idx.push_back(int'(zz_index));
            got_last.push_back(zz_last);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic void chk(string nm, longint got, longint exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", nm, got, exp);
        end
    endfunction

    // Reference: walk anti-diagonals s=r+c, alternating direction
    function automatic void model_push(blk_t b);
        int n = 0;
        for (int s = 0; s < 15; s++) begin
            int lo = (s > 7) ? s - 7 : 0;
            int hi = (s < 7) ? s : 7;
            for (int t = 0; t <= hi - lo; t++) begin
                int r = (s % 2 == 0) ? hi - t : lo + t;
                exp_data.push_back(b[r][s-r]);
                exp_idx.push_back(n);
                exp_last.push_back(n == 63);
                n++;
            end
        end
    endfunction

    function automatic blk_t ramp();
        blk_t b;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) b[r][c] = W'(8 * r + c);
        return b;
    endfunction

    function automatic blk_t fill(int v);
        blk_t b;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) b[r][c] = W'(v);
        return b;
    endfunction

    function automatic blk_t rnd();
        blk_t b;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) b[r][c] = W'($urandom_range(0, 2047));
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        got_data.delete(); got_idx.delete(); got_last.delete();
        exp_data.delete(); exp_idx.delete(); exp_last.delete();
    endtask

    task automatic send(blk_t b);
        int c = 0;
        while (!in_ready && c < 200) begin
            tick();
            c++;
        end
        chk("send_in_ready", in_ready, 1);
        enable = 1'b1;
        q_in = b;
        tick();
        enable = 1'b0;
    endtask

    task automatic collect(int n);
        int c = 0;
        while (got_data.size() < n && c < 2000) begin
            tick();
            c++;
        end
        chk("collect_count", got_data.size(), n);
    endtask

    task automatic wait_k(int k);
        int c = 0;
        while (!(zz_valid && zz_index == 6'(k)) && c < 200) begin
            tick();
            c++;
        end
        chk("wait_index", zz_index, k);
    endtask

    task automatic cmp(string nm);
        chk({nm, "_len"}, got_data.size(), exp_data.size());
        for (int i = 0; i < exp_data.size(); i++) begin
            chk($sformatf("%s_data%0d", nm, i), got_data[i], exp_data[i]);
            chk($sformatf("%s_index%0d", nm, i), got_idx[i], exp_idx[i]);
            chk($sformatf("%s_last%0d", nm, i), got_last[i], exp_last[i]);
        end
    endtask

    initial begin
        blk_t b;
        int nl;
        ramp_tab = '{'{0, 0, 0}, '{1, 1, 0}, '{2, 8, 0}, '{3, 16, 0}, '{4, 9, 0}, '{5, 2, 0},
                     '{6, 3, 0}, '{7, 10, 0}, '{61, 55, 0}, '{62, 62, 0}, '{63, 63, 1}};
        tick();
        tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_valid", zz_valid, 0);
        chk("rst_index", zz_index, 0);
        chk("rst_data", zz_data, 0);
        chk("rst_last", zz_last, 0);
        rst = 1'b0;
        tick();

        clear();
        model_push(ramp());
        send(ramp());
        chk("ramp_first_valid", zz_valid, 1);
        chk("ramp_first_index", zz_index, 0);
        chk("ramp_first_data", zz_data, 0);
        collect(64);
        cmp("ramp");
        foreach (ramp_tab[i]) begin
            chk($sformatf("tab_data%0d", ramp_tab[i].idx), got_data[ramp_tab[i].idx], ramp_tab[i].data);
            chk($sformatf("tab_last%0d", ramp_tab[i].idx), got_last[ramp_tab[i].idx], ramp_tab[i].last);
        end
        nl = 0;
        foreach (got_last[i]) if (got_last[i]) nl++;
        chk("ramp_last_count", nl, 1);

        clear();
        model_push(ramp());
        send(ramp());
        wait_k(5);
        zz_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_index", zz_index, 5);
            chk("bp_data", zz_data, 2);
            chk("bp_valid", zz_valid, 1);
        end
        zz_ready = 1'b1;
        collect(64);
        cmp("bp");

        clear();
        model_push(ramp());
        send(ramp());
        wait_k(20);
        chk("ign_in_ready", in_ready, 0);
        enable = 1'b1;
        q_in = fill(99);
        tick();
        enable = 1'b0;
        collect(64);
        cmp("ign");
        nl = 0;
        foreach (got_data[i]) if (got_data[i] == 99) nl++;
        chk("ign_no_99", nl, 0);

        clear();
        model_push(fill(7));
        model_push(fill(-3));
        send(fill(7));
        repeat (63) tick();
        chk("b2b_k63", zz_index, 63);
        chk("b2b_in_ready", in_ready, 1);
        enable = 1'b1;
        q_in = fill(-3);
        tick();
        enable = 1'b0;
        chk("b2b_valid", zz_valid, 1);
        chk("b2b_index", zz_index, 0);
        chk("b2b_data", zz_data, -3);
        repeat (64) tick();
        chk("b2b_beats", got_data.size(), 128);
        cmp("b2b");

        clear();
        send(ramp());
        wait_k(30);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", zz_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_index", zz_index, 0);
        chk("mid_rst_data", zz_data, 0);
        chk("mid_rst_last", zz_last, 0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("no_resume", zz_valid, 0);
        clear();
        b = fill(1);
        b[0][0] = W'(-1024);
        model_push(b);
        send(b);
        chk("post_rst_data", zz_data, -1024);
        collect(64);
        cmp("post_rst");

        clear();
        b = fill(0);
        b[7][7] = W'(1023);
        b[0][1] = W'(-1024);
        model_push(b);
        send(b);
        collect(64);
        cmp("ext");
        chk("ext_neg", got_data[1], -1024);
        chk("ext_pos", got_data[63], 1023);
        chk("ext_last", got_last[63], 1);

        for (int blk = 0; blk < 8; blk++) begin
            int c = 0;
            clear();
            b = rnd();
            model_push(b);
            zz_ready = 1'b1;
            send(b);
            while (got_data.size() < 64 && c < 2000) begin
                zz_ready = ($urandom_range(0, 3) != 0);
                if (zz_index < 6'd60 && $urandom_range(0, 7) == 0) begin
                    enable = 1'b1;
                    q_in = rnd();
                end else enable = 1'b0;
                tick();
                c++;
            end
            enable = 1'b0;
            zz_ready = 1'b1;
            chk("rand_count", got_data.size(), 64);
            cmp($sformatf("rand%0d", blk));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
